// File: rtl/bullet_scheduler.sv
// Bullet pool owner: round-robin shoot arbitration, lowest-free-slot allocation, per-tick movement sweep.
// Latency: shoot_ack combinational, slot write next edge; sweep takes N_SLOTS cycles; read port 1 cycle.
// Backpressure: requests are held pending (no ack) while sweeping; optional SHOOT_COOLDOWN_EN masks recent shooters.
module bullet_scheduler #(
    parameter int N_TANKS        = 4,
    parameter int N_SLOTS        = 16,
    parameter int SLOT_W         = 4,
    parameter int FIELD_W        = 60,
    parameter int FIELD_H        = 45,
    parameter int COOLDOWN_TICKS = 2
) (
    input  logic                    clk_100mhz,
    input  logic                    rst,
    input  logic                    tick,
    input  logic [N_TANKS-1:0]      shoot_req,
    input  logic [10*N_TANKS-1:0]   shoot_x,
    input  logic [10*N_TANKS-1:0]   shoot_y,
    input  logic [3*N_TANKS-1:0]    shoot_dir,
    output logic [N_TANKS-1:0]      shoot_ack,
    output logic                    dropped,
    output logic                    busy,
    output logic                    overrun,
    output logic [SLOT_W:0]         n_active,
    input  logic [SLOT_W-1:0]       rd_idx,
    output logic                    rd_valid,
    output logic [9:0]              rd_x,
    output logic [9:0]              rd_y
);

    localparam int TANK_W = (N_TANKS > 1) ? $clog2(N_TANKS) : 1;
    localparam logic [9:0]        X_MAX     = 10'(FIELD_W - 1);
    localparam logic [9:0]        Y_MAX     = 10'(FIELD_H - 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_SLOTS - 1);
    localparam logic [SLOT_W:0]   POOL_MAX  = (SLOT_W+1)'(N_SLOTS);
    localparam logic [TANK_W-1:0] LAST_TANK = TANK_W'(N_TANKS - 1);
    localparam logic [1:0] DIR_LEFT  = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_UP    = 2'd2;
    localparam logic [1:0] DIR_DOWN  = 2'd3;

    typedef enum logic {S_IDLE, S_SWEEP} state_t;

    state_t              state_q, state_d;
    logic [SLOT_W-1:0]   ptr_q, ptr_d;
    logic [TANK_W-1:0]   rr_q, rr_d;
    logic [SLOT_W:0]     n_active_q, n_active_d;
    logic                dropped_q, dropped_d;
    logic                overrun_q, overrun_d;
    logic                valid_q [N_SLOTS];
    logic                valid_d [N_SLOTS];
    logic [9:0]          x_q [N_SLOTS];
    logic [9:0]          x_d [N_SLOTS];
    logic [9:0]          y_q [N_SLOTS];
    logic [9:0]          y_d [N_SLOTS];
    logic [1:0]          dir_q [N_SLOTS];
    logic [1:0]          dir_d [N_SLOTS];
    logic                rd_valid_q, rd_valid_d;
    logic [9:0]          rd_x_q, rd_x_d;
    logic [9:0]          rd_y_q, rd_y_d;

    logic [N_TANKS-1:0]  cd_mask;
    logic [N_TANKS-1:0]  req_eff;
    logic                can_grant;
    logic                tick_accept;
    logic                grant_vld;
    logic [TANK_W-1:0]   grant_idx;
    int                  t_idx;
    logic [9:0]          g_x, g_y;
    logic [2:0]          g_dir;
    logic                free_found;
    logic [SLOT_W-1:0]   free_idx;
    logic                alloc_ok;
    logic [9:0]          sx, sy, step_x, step_y;
    logic                exit_edge;

    assign can_grant   = (state_q == S_IDLE) && !tick && !rst;
    assign tick_accept = (state_q == S_IDLE) && tick;
    assign req_eff     = shoot_req & ~cd_mask;

    // Round-robin search for the first eligible requester starting at rr_q.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        t_idx     = 0;
        for (int k = 0; k < N_TANKS; k++) begin
            t_idx = int'(rr_q) + k;
            if (t_idx >= N_TANKS) t_idx = t_idx - N_TANKS;
            if (!grant_vld && req_eff[t_idx]) begin
                grant_vld = 1'b1;
                grant_idx = TANK_W'(t_idx);
            end
        end
    end

    // Ack is only visible in cycles where the grant is actually consumed.
    always_comb begin
        shoot_ack = '0;
        if (can_grant && grant_vld) shoot_ack[grant_idx] = 1'b1;
    end

    // Granted request fields, lowest free slot and legality check.
    always_comb begin
        g_x        = shoot_x[int'(grant_idx)*10 +: 10];
        g_y        = shoot_y[int'(grant_idx)*10 +: 10];
        g_dir      = shoot_dir[int'(grant_idx)*3 +: 3];
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = SLOT_W'(i);
            end
        end
        alloc_ok = (n_active_q != POOL_MAX) && free_found && (g_dir <= 3'd3)
                   && (g_x <= X_MAX) && (g_y <= Y_MAX);
    end

    // Movement of the slot under the sweep pointer; edge checks keep the
    // unsigned arithmetic from ever wrapping.
    always_comb begin
        sx        = x_q[ptr_q];
        sy        = y_q[ptr_q];
        step_x    = sx;
        step_y    = sy;
        exit_edge = 1'b0;
        case (dir_q[ptr_q])
            DIR_LEFT:  if (sx == 10'd0) exit_edge = 1'b1; else step_x = sx - 10'd1;
            DIR_RIGHT: if (sx == X_MAX) exit_edge = 1'b1; else step_x = sx + 10'd1;
            DIR_UP:    if (sy == 10'd0) exit_edge = 1'b1; else step_y = sy - 10'd1;
            default:   if (sy == Y_MAX) exit_edge = 1'b1; else step_y = sy + 10'd1;
        endcase
    end

    // FSM next state plus pool updates: allocate in IDLE, advance/retire in SWEEP.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rr_d       = rr_q;
        n_active_d = n_active_q;
        dropped_d  = 1'b0;
        overrun_d  = 1'b0;
        valid_d    = valid_q;
        x_d        = x_q;
        y_d        = y_q;
        dir_d      = dir_q;
        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    state_d = S_SWEEP;
                    ptr_d   = '0;
                end else if (grant_vld) begin
                    rr_d = (grant_idx == LAST_TANK) ? '0 : grant_idx + 1'b1;
                    if (alloc_ok) begin
                        valid_d[free_idx] = 1'b1;
                        x_d[free_idx]     = g_x;
                        y_d[free_idx]     = g_y;
                        dir_d[free_idx]   = g_dir[1:0];
                        n_active_d        = n_active_q + 1'b1;
                    end else begin
                        dropped_d = 1'b1;
                    end
                end
            end
            S_SWEEP: begin
                overrun_d = tick;
                if (valid_q[ptr_q]) begin
                    if (exit_edge) begin
                        valid_d[ptr_q] = 1'b0;
                        n_active_d     = n_active_q - 1'b1;
                    end else begin
                        x_d[ptr_q] = step_x;
                        y_d[ptr_q] = step_y;
                    end
                end
                if (ptr_q == LAST_SLOT) begin
                    state_d = S_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Registered renderer read port; sees slot contents before this edge's update.
    always_comb begin
        rd_valid_d = valid_q[rd_idx];
        rd_x_d     = x_q[rd_idx];
        rd_y_d     = y_q[rd_idx];
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            rr_q       <= '0;
            n_active_q <= '0;
            dropped_q  <= 1'b0;
            overrun_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_x_q     <= '0;
            rd_y_q     <= '0;
            for (int i = 0; i < N_SLOTS; i++) begin
                valid_q[i] <= 1'b0;
                x_q[i]     <= '0;
                y_q[i]     <= '0;
                dir_q[i]   <= '0;
            end
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rr_q       <= rr_d;
            n_active_q <= n_active_d;
            dropped_q  <= dropped_d;
            overrun_q  <= overrun_d;
            rd_valid_q <= rd_valid_d;
            rd_x_q     <= rd_x_d;
            rd_y_q     <= rd_y_d;
            valid_q    <= valid_d;
            x_q        <= x_d;
            y_q        <= y_d;
            dir_q      <= dir_d;
        end
    end

`ifdef SHOOT_COOLDOWN_EN
    logic [7:0] cd_q [N_TANKS];
    logic [7:0] cd_d [N_TANKS];

    // Per-tank hold-off: loaded on any ack, counted down once per sweep start.
    always_comb begin
        cd_d = cd_q;
        for (int i = 0; i < N_TANKS; i++) begin
            cd_mask[i] = (cd_q[i] != 8'd0);
            if (tick_accept && cd_q[i] != 8'd0) cd_d[i] = cd_q[i] - 8'd1;
            if (shoot_ack[i]) cd_d[i] = 8'(COOLDOWN_TICKS);
        end
    end

    // Cooldown counter registers.
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            for (int i = 0; i < N_TANKS; i++) cd_q[i] <= '0;
        end else begin
            cd_q <= cd_d;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{8'(COOLDOWN_TICKS), tick_accept};
    assign cd_mask    = '0;
`endif

    assign busy     = (state_q == S_SWEEP);
    assign dropped  = dropped_q;
    assign overrun  = overrun_q;
    assign n_active = n_active_q;
    assign rd_valid = rd_valid_q;
    assign rd_x     = rd_x_q;
    assign rd_y     = rd_y_q;

endmodule
